mix_columns_add_key_serial: RTL and testbench
=============================================

# mix_columns_add_key_serial

Column-serial MixColumns + AddRoundKey stage for the iterative AES-128 round datapath. Sits directly downstream of SubBytes/ShiftRows and feeds the round-state register. It accepts a 128-bit state and a 128-bit round key, and applies the existing single-column `mixColumn` block to one column per cycle, so only one instance is needed. Each column result is XORed with the matching round-key column, and the 128-bit result is presented on a valid/ready output. A last-round flag bypasses MixColumns.

## Interface
- No parameters.
- Clk_CI  input  1  rising-edge clock; one clock domain.
- Reset_RBI  input  1  asynchronous, active-low reset.
- In_Valid_SI  input  1  input transfer request.
- In_Ready_SO  output  1  stage can accept a new input.
- State_DI  input  128  input state.
- RoundKey_DI  input  128  round key.
- LastRound_SI  input  1  1 = skip MixColumns and output State^Key; sampled with the input transfer.
- Out_Valid_SO  output  1  result available.
- Out_Ready_SI  input  1  consumer takes the result.
- State_DO  output  128  result state.

## Operation
- Byte order follows FIPS-197:
  - Byte n (0..15) sits at bits [127-8n -: 8].
  - Column c holds bytes 4c..4c+3.
  - Byte 4c+r is element r of the `Word` driven into `mixColumn` (element 0 = row 0).
- Input transfer happens on a rising edge with In_Valid_SI && In_Ready_SO. On that edge:
  - State_DI, RoundKey_DI and LastRound_SI are captured into internal registers.
  - Inputs may change freely afterwards.
- FSM states:
  - IDLE: In_Ready_SO=1, Out_Valid_SO=0. Transfer → BUSY with column counter Col=0.
  - BUSY: In_Ready_SO=0, Out_Valid_SO=0. Each edge writes result column Col into the output register and increments Col (2 bits). At Col=3 the next edge → DONE with Col wrapping to 0.
  - DONE: Out_Valid_SO=1.
    - Out_Ready_SI=1 with no new input → IDLE.
    - Out_Ready_SI=1 with In_Valid_SI=1 → BUSY, Col=0. In the same cycle the new input is captured and the old result is consumed.
    - Out_Ready_SI=0 → stay in DONE, with State_DO held stable.
- In_Ready_SO = (state==IDLE) || (state==DONE && Out_Ready_SI). The combinational path from Out_Ready_SI is permitted.
- Column result:
  - LastRound=0: mixColumn(captured state column Col) ^ key column Col.
  - LastRound=1: state column Col ^ key column Col.
- A single `mixColumn` instance is used; its input is selected by Col.
- Output register bytes for columns not yet written hold undefined-but-deterministic previous contents. The consumer only looks at State_DO when Out_Valid_SO=1.
- All arithmetic is GF(2^8) via `mixColumn` and bitwise XOR. There are no carries or width changes.

## Timing
- Reset (asynchronous, takes effect immediately):
  - FSM=IDLE, Col=0.
  - Capture registers and output register cleared to 0.
  - Out_Valid_SO=0, State_DO=128'h0.
  - In_Ready_SO=1 once reset is released.
- Latency:
  - Input accepted at edge E0 → Out_Valid_SO rises after E4 (4 cycles).
  - Column c is written at edge E(c+1).
- Throughput: with Out_Ready_SI held high, one result every 5 cycles. The DONE cycle overlaps the next acceptance.
- Output stability: State_DO and Out_Valid_SO come only from registers. Both stay unchanged while Out_Valid_SO=1 && Out_Ready_SI=0.
- Reset asserted mid-BUSY or in DONE: the operation is abandoned and the stage returns to the reset values above. No partial output is ever flagged valid.
- In_Valid_SI in BUSY is ignored because In_Ready_SO=0. The upstream stage holds its data until the transfer.

## Test plan
- Reset check: assert Reset_RBI mid-run → Out_Valid_SO=0 and State_DO=0 immediately. In_Ready_SO=1 after release.
- MixColumns vector: State=db135345_f20a225c_01010101_c6c6c6c6, Key=0, LastRound=0.
  - Out_Valid_SO rises exactly 4 cycles after acceptance.
  - State_DO=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- AddRoundKey + last round: State=00112233_44556677_8899aabb_ccddeeff, Key=000102030405060708090a0b0c0d0e0f, LastRound=1 → State_DO=00102030_40506070_8090a0b0_c0d0e0f0.
- Backpressure: hold Out_Ready_SI=0 for 10 cycles after Out_Valid_SO rises.
  - State_DO stays stable and In_Ready_SO=0 throughout.
  - Release → result taken once, stage returns to IDLE.
- Back-to-back: keep In_Valid_SI=1 and Out_Ready_SI=1 with 3 distinct vectors.
  - Acceptances are exactly 5 cycles apart.
  - Each result matches the reference model, and none is dropped or duplicated.
- Mid-operation reset: assert reset 2 cycles after acceptance → no Out_Valid_SO pulse. A subsequent fresh vector completes correctly.

Source files
------------

// File: rtl/mix_columns_add_key_serial.sv
// Column-serial AES MixColumns + AddRoundKey stage: one mixColumn instance
// processes one column per cycle; the last round bypasses MixColumns.
`timescale 1ns/1ps

module mixColumn (
  input  logic [3:0][7:0] in_word,
  output logic [3:0][7:0] out_word
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Element 0 is row 0: out[r] = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
  always_comb begin
    out_word = '0;
    for (int r = 0; r < 4; r++) begin
      out_word[r] = xtime(in_word[r])
                  ^ xtime(in_word[2'(r + 1)]) ^ in_word[2'(r + 1)]
                  ^ in_word[2'(r + 2)]
                  ^ in_word[2'(r + 3)];
    end
  end

endmodule

module mix_columns_add_key_serial (
  input  logic         Clk_CI,
  input  logic         Reset_RBI,
  input  logic         In_Valid_SI,
  output logic         In_Ready_SO,
  input  logic [127:0] State_DI,
  input  logic [127:0] RoundKey_DI,
  input  logic         LastRound_SI,
  output logic         Out_Valid_SO,
  input  logic         Out_Ready_SI,
  output logic [127:0] State_DO
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   cap_state_q, cap_state_d;
  logic [127:0]   cap_key_q, cap_key_d;
  logic           last_q, last_d;
  logic [127:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;

  logic [31:0]    state_col, key_col, col_res;
  logic [3:0][7:0] mix_in, mix_out;
  logic           accept;

  assign In_Ready_SO  = (state_q == IDLE) || (state_q == DONE && Out_Ready_SI);
  assign accept       = In_Valid_SI && In_Ready_SO;
  assign Out_Valid_SO = out_valid_q;
  assign State_DO     = out_q;

  always_comb begin
    state_col = 32'h0;
    key_col   = 32'h0;
    unique case (col_q)
      2'd0: begin state_col = cap_state_q[127:96]; key_col = cap_key_q[127:96]; end
      2'd1: begin state_col = cap_state_q[95:64];  key_col = cap_key_q[95:64];  end
      2'd2: begin state_col = cap_state_q[63:32];  key_col = cap_key_q[63:32];  end
      default: begin state_col = cap_state_q[31:0]; key_col = cap_key_q[31:0]; end
    endcase
  end

  // The top byte of a column is row 0, which is element 0 of the mixColumn word
  assign mix_in = {state_col[7:0], state_col[15:8], state_col[23:16], state_col[31:24]};

  mixColumn u_mix_column (
    .in_word  (mix_in),
    .out_word (mix_out)
  );

  assign col_res = (last_q ? state_col : {mix_out[0], mix_out[1], mix_out[2], mix_out[3]})
                 ^ key_col;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cap_state_d = cap_state_q;
    cap_key_d   = cap_key_q;
    last_d      = last_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      cap_state_d = State_DI;
      cap_key_d   = RoundKey_DI;
      last_d      = LastRound_SI;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          col_d   = 2'd0;
        end
      end
      BUSY: begin
        unique case (col_q)
          2'd0:    out_d[127:96] = col_res;
          2'd1:    out_d[95:64]  = col_res;
          2'd2:    out_d[63:32]  = col_res;
          default: out_d[31:0]   = col_res;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (Out_Ready_SI) begin
          out_valid_d = 1'b0;
          col_d       = 2'd0;
          state_d     = accept ? BUSY : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        col_d       = 2'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      cap_state_q <= 128'h0;
      cap_key_q   <= 128'h0;
      last_q      <= 1'b0;
      out_q       <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cap_state_q <= cap_state_d;
      cap_key_q   <= cap_key_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_add_key_serial.sv
// Directed bench for mix_columns_add_key_serial: FIPS-197 derived vectors,
// latency, backpressure, back-to-back throughput and mid-operation reset.
`timescale 1ns/1ps

module tb_mix_columns_add_key_serial;

  typedef struct {
    logic [127:0] state;
    logic [127:0] key;
    logic         last;
    logic [127:0] expected;
  } vec_t;

  localparam int NUM_VECS = 6;
  localparam int TIMEOUT  = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_di;
  logic [127:0] key_di;
  logic         last_si;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_do;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  vec_t vecs[NUM_VECS];

  mix_columns_add_key_serial dut (
    .Clk_CI       (clk),
    .Reset_RBI    (rst_n),
    .In_Valid_SI  (in_valid),
    .In_Ready_SO  (in_ready),
    .State_DI     (state_di),
    .RoundKey_DI  (key_di),
    .LastRound_SI (last_si),
    .Out_Valid_SO (out_valid),
    .Out_Ready_SI (out_ready),
    .State_DO     (state_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    state_di = v.state;
    key_di   = v.key;
    last_si  = v.last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      tick();
      lat++;
    end
  endtask

  // Accept one vector from IDLE, scramble the inputs, and check latency and result
  task automatic run_vector(input int idx, input string name);
    int lat;
    apply_stimulus(vecs[idx]);
    in_valid = 1'b1;
    check_output({name, "_ready_idle"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    state_di = ~vecs[idx].state;
    key_di   = ~vecs[idx].key;
    last_si  = ~vecs[idx].last;
    check_output({name, "_ready_busy"}, 128'(in_ready), 128'(0));
    wait_valid(lat);
    check_output({name, "_latency"}, 128'(lat), 128'(4));
    check_output({name, "_result"}, state_do, vecs[idx].expected);
  endtask

  initial begin
    int   lat;
    int   g;
    int   res_count;
    int   acc_t[3];
    logic seen;
    logic [127:0] held;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h0, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'h00112233_44556677_8899aabb_ccddeeff, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1,
                128'h00102030_40506070_8090a0b0_c0d0e0f0};
    vecs[2] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, {128{1'b1}}, 1'b0,
                128'h71b25e43_6023a762_fefefefe_39393939};
    vecs[3] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0,
                128'ha49c7ff2_689f352b_6b5bea43_026a5049};
    vecs[4] = '{128'h01234567_89abcdef_fedcba98_76543210, 128'h0, 1'b1,
                128'h01234567_89abcdef_fedcba98_76543210};
    vecs[5] = '{128'h0, 128'h0, 1'b0, 128'h0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_di  = '0;
    key_di    = '0;
    last_si   = 1'b0;

    #2;
    check_output("reset_valid", 128'(out_valid), 128'(0));
    check_output("reset_state", state_do, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("reset_ready", 128'(in_ready), 128'(1));
    tick();

    for (int i = 0; i < NUM_VECS; i++) begin
      run_vector(i, $sformatf("vec%0d", i));
      tick();
      check_output($sformatf("vec%0d_consumed", i), 128'(out_valid), 128'(0));
    end

    // Backpressure: result must stay frozen while the consumer stalls
    out_ready = 1'b0;
    run_vector(3, "bp");
    held = state_do;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      tick();
      if (state_do !== held || out_valid !== 1'b1 || in_ready !== 1'b0) seen = 1'b1;
    end
    check_output("bp_stable", 128'(seen), 128'(0));
    check_output("bp_held_value", state_do, vecs[3].expected);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_output("bp_release_ready", 128'(in_ready), 128'(1));
    tick();
    check_output("bp_taken_valid", 128'(out_valid), 128'(0));
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check_output("bp_no_duplicate", 128'(seen), 128'(0));
    check_output("bp_idle_ready", 128'(in_ready), 128'(1));

    // Back-to-back with In_Valid and Out_Ready held high
    res_count = 0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(vecs[k + 2]);
      g = 0;
      while (!in_ready && g < TIMEOUT) begin
        tick();
        g++;
      end
      if (g >= TIMEOUT) begin
        errors++;
        $display("[TB] FAIL b2b_ready_timeout: vector %0d never accepted", k);
      end
      if (out_valid) begin
        check_output($sformatf("b2b_result%0d", res_count), state_do, vecs[res_count + 2].expected);
        res_count++;
      end
      @(posedge clk);
      #1;
      acc_t[k] = cycle_cnt;
    end
    in_valid = 1'b0;
    wait_valid(lat);
    if (out_valid && res_count < 3) begin
      check_output($sformatf("b2b_result%0d", res_count), state_do, vecs[res_count + 2].expected);
      res_count++;
    end
    check_output("b2b_count", 128'(res_count), 128'(3));
    check_output("b2b_gap01", 128'(acc_t[1] - acc_t[0]), 128'(5));
    check_output("b2b_gap12", 128'(acc_t[2] - acc_t[1]), 128'(5));
    tick();
    check_output("b2b_final_consumed", 128'(out_valid), 128'(0));

    // Reset two cycles after acceptance must abandon the operation
    apply_stimulus(vecs[3]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", 128'(out_valid), 128'(0));
    check_output("midrst_state", state_do, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("midrst_ready", 128'(in_ready), 128'(1));
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check_output("midrst_no_pulse", 128'(seen), 128'(0));
    run_vector(0, "post_rst");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
